// File: rtl/bridge_rx_if.sv
// UART-byte input and core-bus output of the receive bridge.
// The bridge is the slave side; the master side drives bytes and observes transactions.
interface bridge_rx_if;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [15:0] addr_o;
  logic [15:0] data_o;
  logic        rw_o;
  logic        valid_o;

  modport slave (
    input  data_i, valid_i,
    output addr_o, data_o, rw_o, valid_o
  );

  modport master (
    output data_i, valid_i,
    input  addr_o, data_o, rw_o, valid_o
  );
endinterface

// File: rtl/bridge_rx.sv
// Parses ASCII "Raaaa<term>" / "Waaaadddd<term>" requests into single-cycle bus
// transactions; malformed messages are dropped, with R/W resyncing a new message.
module bridge_rx (
  input  logic        clk,
  input  logic        rst,
  bridge_rx_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_TERM} state_t;

  state_t      r_state, w_state_n;
  logic [1:0]  r_cnt, w_cnt_n;
  logic [15:0] r_addr_sh, w_addr_sh_n;
  logic [15:0] r_data_sh, w_data_sh_n;
  logic        r_rw, w_rw_n;
  logic        w_commit;

  logic [15:0] r_addr;
  logic [15:0] r_data;
  logic        r_rw_o;
  logic        r_valid;

  logic        w_is_hex;
  logic [3:0]  w_nib;
  logic        w_is_term;
  logic        w_is_r;
  logic        w_is_w;

  always_comb begin
    w_is_hex = 1'b0;
    w_nib    = '0;
    if (bus.data_i >= 8'h30 && bus.data_i <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nib    = bus.data_i[3:0];
    end else if ((bus.data_i >= 8'h41 && bus.data_i <= 8'h46) ||
                 (bus.data_i >= 8'h61 && bus.data_i <= 8'h66)) begin
      w_is_hex = 1'b1;
      w_nib    = bus.data_i[3:0] + 4'd9;
    end
  end

  assign w_is_term = (bus.data_i == 8'h0D) || (bus.data_i == 8'h0A);
  assign w_is_r    = (bus.data_i == 8'h52);
  assign w_is_w    = (bus.data_i == 8'h57);

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_addr_sh_n = r_addr_sh;
    w_data_sh_n = r_data_sh;
    w_rw_n      = r_rw;
    w_commit    = 1'b0;
    if (bus.valid_i) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_is_r || w_is_w) begin
            w_state_n = S_ADDR;
            w_rw_n    = w_is_w;
            w_cnt_n   = '0;
          end
        end
        S_ADDR: begin
          if (w_is_hex) begin
            w_addr_sh_n = {r_addr_sh[11:0], w_nib};
            w_cnt_n     = r_cnt + 2'd1;
            if (r_cnt == 2'd3)
              w_state_n = r_rw ? S_DATA : S_TERM;
          end else begin
            w_state_n = S_IDLE;
          end
        end
        S_DATA: begin
          if (w_is_hex) begin
            w_data_sh_n = {r_data_sh[11:0], w_nib};
            w_cnt_n     = r_cnt + 2'd1;
            if (r_cnt == 2'd3)
              w_state_n = S_TERM;
          end else begin
            w_state_n = S_IDLE;
          end
        end
        S_TERM: begin
          w_state_n = S_IDLE;
          if (w_is_term)
            w_commit = 1'b1;
        end
        default: w_state_n = S_IDLE;
      endcase

      // Any abort (fell back to IDLE without committing) restarts on an R/W byte.
      if (r_state != S_IDLE && w_state_n == S_IDLE && !w_commit) begin
        w_cnt_n = '0;
        if (w_is_r || w_is_w) begin
          w_state_n = S_ADDR;
          w_rw_n    = w_is_w;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr_sh <= '0;
      r_data_sh <= '0;
      r_rw      <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_addr_sh <= w_addr_sh_n;
      r_data_sh <= w_data_sh_n;
      r_rw      <= w_rw_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_rw_o  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_commit;
      if (w_commit) begin
        r_addr <= r_addr_sh;
        r_data <= r_rw ? r_data_sh : '0;
        r_rw_o <= r_rw;
      end
    end
  end

  assign bus.addr_o  = r_addr;
  assign bus.data_o  = r_data;
  assign bus.rw_o    = r_rw_o;
  assign bus.valid_o = r_valid;

endmodule
